// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, counter width and default parameters for the reset sequencer
// Contents: seq_state_t (HOLD/WAIT_ACK/RUN/ERROR), CNT_W, DEF_* parameter defaults.
package reset_seq_pkg;

    localparam int CNT_W           = 8;
    localparam int DEF_N_STAGES    = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RUN      = 2'd2,
        ST_ERROR    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - request/ack/status bundle between the reset sequencer and its reset domains
// Signals: sw_reset_req, stage_ack[N_STAGES] (into sequencer);
//          rst_out[N_STAGES], stage_idx[3], busy, done, error (out of sequencer).
// Modports: master = sequencer side, slave = domain/software side.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES = DEF_N_STAGES
);

    logic                sw_reset_req;
    logic [N_STAGES-1:0] stage_ack;
    logic [N_STAGES-1:0] rst_out;
    logic [2:0]          stage_idx;
    logic                busy;
    logic                done;
    logic                error;

    modport master (
        input  sw_reset_req, stage_ack,
        output rst_out, stage_idx, busy, done, error
    );

    modport slave (
        output sw_reset_req, stage_ack,
        input  rst_out, stage_idx, busy, done, error
    );

endinterface

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - loadable down-counter with zero flag, shared by the hold and ack-timeout counts
// Ports: clk; load (synchronous load, wins over decrement); load_val[CNT_W]; zero (count is 0).
module seq_timer
    import reset_seq_pkg::*;
(
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    // No reset of its own: the sequencer asserts load whenever it is reset.
    always_ff @(posedge clk) begin
        if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases N_STAGES reset domains in order, gated by per-stage acks with timeout
// Ports: clk; reset (sync, active-high); bus (reset_sequencer_if.master):
//        sw_reset_req, stage_ack in; rst_out, stage_idx, busy, done, error out (all registered).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master bus
);

    // The timer flags zero N-1 edges after loading N-1, so the decision edge
    // that sees zero is exactly N edges after the load edge.
    localparam logic [CNT_W-1:0]    HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    TMO_LOAD  = CNT_W'(TIMEOUT - 1);
    localparam logic [N_STAGES-1:0] ALL_ONES  = '1;

    seq_state_t          state_q, state_d;
    logic [N_STAGES-1:0] rst_q, rst_d;
    logic [2:0]          idx_q, idx_d;
    logic                busy_q, done_q, error_q;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_zero;
    logic                ack_sel;
    logic [N_STAGES-1:0] cur_mask;
    logic [N_STAGES-1:0] next_mask;

    seq_timer u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Only the ack of the stage being waited on matters.
    assign cur_mask  = N_STAGES'(1) << idx_q;
    assign next_mask = N_STAGES'(1) << (idx_q + 3'd1);
    assign ack_sel   = |(bus.stage_ack & cur_mask);

    always_comb begin
        state_d  = state_q;
        rst_d    = rst_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = HOLD_LOAD;

        if (reset || bus.sw_reset_req) begin
            state_d  = ST_HOLD;
            rst_d    = ALL_ONES;
            idx_d    = 3'd0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (tmr_zero) begin
                        state_d  = ST_WAIT_ACK;
                        rst_d    = ALL_ONES;
                        rst_d[0] = 1'b0;
                        idx_d    = 3'd0;
                        tmr_load = 1'b1;
                        tmr_val  = TMO_LOAD;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is checked before expiry so a last-edge ack still advances.
                    if (ack_sel) begin
                        if (int'(idx_q) == N_STAGES - 1) begin
                            state_d = ST_RUN;
                        end else begin
                            rst_d    = rst_q & ~next_mask;
                            idx_d    = idx_q + 3'd1;
                            tmr_load = 1'b1;
                            tmr_val  = TMO_LOAD;
                        end
                    end else if (tmr_zero) begin
                        state_d = ST_ERROR;
                        rst_d   = ALL_ONES;
                    end
                end
                ST_RUN:   ;
                ST_ERROR: ;
                default: begin
                    state_d = ST_ERROR;
                    rst_d   = ALL_ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
            rst_q   <= ALL_ONES;
            idx_q   <= 3'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d == ST_HOLD) || (state_d == ST_WAIT_ACK);
            done_q  <= (state_d == ST_RUN);
            error_q <= (state_d == ST_ERROR);
        end
    end

    assign bus.rst_out   = rst_q;
    assign bus.stage_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (N_STAGES=4, HOLD_CYCLES=16, TIMEOUT=20)
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reset_sequencer_if #(.N_STAGES(N)) bus ();

    reset_sequencer #(
        .N_STAGES    (N),
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, want);
        end
    endtask

    // Packed view: {error, done, busy, stage_idx[2:0], rst_out[3:0]}
    function automatic logic [9:0] pk(input logic [3:0] r, input int idx,
                                      input logic b, input logic d, input logic e);
        return {e, d, b, 3'(idx), r};
    endfunction

    function automatic logic [9:0] hold_v();
        return pk(4'b1111, 0, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [9:0] wait_v(input logic [3:0] r, input int idx);
        return pk(r, idx, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [9:0] run_v();
        return pk(4'b0000, 3, 1'b0, 1'b1, 1'b0);
    endfunction

    function automatic logic [9:0] err_v(input int idx);
        return pk(4'b1111, idx, 1'b0, 1'b0, 1'b1);
    endfunction

    // Push the expectation for the coming edge, then pop and compare after it.
    task automatic cyc(input string tag, input logic [9:0] e);
        logic [9:0] want;
        logic [9:0] got;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {bus.error, bus.done, bus.busy, bus.stage_idx, bus.rst_out};
        want = exp_q.pop_front();
        check(tag, 32'(got), 32'(want));
    endtask

    // Called right after the edge that (re)entered HOLD: 15 more held edges, release on the 16th.
    task automatic hold_release(input string tag);
        for (int i = 0; i < HOLD - 1; i++) cyc({tag, "_hold"}, hold_v());
        cyc({tag, "_rel0"}, wait_v(4'b1110, 0));
    endtask

    initial begin
        reset            = 1'b1;
        bus.sw_reset_req = 1'b0;
        bus.stage_ack    = '0;
        cyc("reset_a", hold_v());
        cyc("reset_b", hold_v());

        // Straight sequence with every ack tied high.
        reset         = 1'b0;
        bus.stage_ack = 4'b1111;
        hold_release("seq");
        cyc("seq_st1", wait_v(4'b1100, 1));
        cyc("seq_st2", wait_v(4'b1000, 2));
        cyc("seq_st3", wait_v(4'b0000, 3));
        cyc("seq_run", run_v());
        bus.stage_ack = 4'b0000;
        for (int i = 0; i < 3; i++) cyc("run_ack_drop", run_v());

        // Software request in RUN, then a late ack on stage 1 with other acks high.
        bus.sw_reset_req = 1'b1;
        cyc("sw_in_run", hold_v());
        bus.sw_reset_req = 1'b0;
        bus.stage_ack    = 4'b0001;
        hold_release("late");
        cyc("late_st1", wait_v(4'b1100, 1));
        bus.stage_ack = 4'b1101;
        for (int i = 0; i < 5; i++) cyc("late_wait1", wait_v(4'b1100, 1));
        bus.stage_ack = 4'b0010;
        cyc("late_ack1", wait_v(4'b1000, 2));

        // Stage 2 never acks: timeout into a sticky ERROR.
        bus.stage_ack = 4'b1011;
        for (int i = 0; i < TMO - 1; i++) cyc("tmo_wait2", wait_v(4'b1000, 2));
        cyc("tmo_error", err_v(2));
        bus.stage_ack = 4'b1111;
        for (int i = 0; i < 3; i++) cyc("err_sticky", err_v(2));
        bus.sw_reset_req = 1'b1;
        bus.stage_ack    = 4'b0011;
        cyc("sw_in_error", hold_v());
        bus.sw_reset_req = 1'b0;

        // Stage 2 acks on exactly the expiry edge.
        hold_release("edge");
        cyc("edge_st1", wait_v(4'b1100, 1));
        cyc("edge_st2", wait_v(4'b1000, 2));
        for (int i = 0; i < TMO - 1; i++) cyc("edge_wait2", wait_v(4'b1000, 2));
        bus.stage_ack = 4'b0111;
        cyc("edge_ack2", wait_v(4'b0000, 3));
        bus.stage_ack = 4'b1111;
        cyc("edge_run", run_v());

        // Software request racing an ack on stage 1.
        bus.stage_ack    = 4'b0001;
        bus.sw_reset_req = 1'b1;
        cyc("sw_run2", hold_v());
        bus.sw_reset_req = 1'b0;
        hold_release("race");
        cyc("race_st1", wait_v(4'b1100, 1));
        bus.stage_ack    = 4'b0011;
        bus.sw_reset_req = 1'b1;
        cyc("sw_vs_ack", hold_v());
        bus.sw_reset_req = 1'b0;
        bus.stage_ack    = 4'b0000;
        hold_release("race2");

        // Reset in the middle of HOLD restarts the full hold count.
        bus.sw_reset_req = 1'b1;
        cyc("sw_in_wait", hold_v());
        bus.sw_reset_req = 1'b0;
        for (int i = 0; i < 10; i++) cyc("mid_hold", hold_v());
        reset = 1'b1;
        cyc("reset_mid", hold_v());
        reset = 1'b0;
        hold_release("rehold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
